// File: rtl/mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mixer_pkg
//  Description : Shared types and helpers for the mixer channel arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mixer_pkg;

    // Arbiter FSM: idle, issue strobe, waiting for I beat, waiting for Q beat
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_I = 2'd2,
        WAIT_Q = 2'd3
    } arb_state_t;

    // Index width for n channels; never narrower than one bit
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mixer_channel_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Grants the lowest request
//                strictly above ptr_i, falling back to the lowest request
//                overall when nothing above the pointer is pending.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import mixer_pkg::*;
#(
    parameter int N = 4
)(
    input  logic [N-1:0]            req_i,
    input  logic [ch_bits(N)-1:0]   ptr_i,
    output logic [ch_bits(N)-1:0]   gnt_idx_o,
    output logic                    gnt_any_o
);

    localparam int IW = ch_bits(N);

    logic [N-1:0] w_above;
    logic [N-1:0] w_use;

    // Requests positioned after the pointer get first chance
    always_comb begin
        w_above = '0;
        for (int i = 0; i < N; i++) begin
            w_above[i] = req_i[i] && (i > int'(ptr_i));
        end
    end

    // Lowest set bit of the masked vector, or of the full vector on wrap
    always_comb begin
        gnt_idx_o = '0;
        gnt_any_o = |req_i;
        w_use     = (|w_above) ? w_above : req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_use[i]) begin
                gnt_idx_o = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mixer_channel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mixer_channel_arbiter
//  Description : Shares one mixer between NCH sample streams. Each channel
//                has a one-entry holding register; a round-robin grant issues
//                one sample, then the I and Q output beats are tracked before
//                the next issue. A watchdog aborts a sample the mixer never
//                completes.
//  Revision    : 1.0  initial release
// ============================================================================
module mixer_channel_arbiter
    import mixer_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCH*DW-1:0]         ch_data_i,
    input  logic [NCH-1:0]            ch_valid_i,
    output logic [NCH-1:0]            ch_ready_o,
    output logic [DW-1:0]             mix_data_o,
    output logic                      mix_valid_o,
    input  logic                      mix_ovalid_i,
    input  logic                      mix_olast_i,
    input  logic                      mix_oready_i,
    output logic [ch_bits(NCH)-1:0]   chan_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int                CH_BITS   = ch_bits(NCH);
    localparam int                CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]     CNT_LIMIT = CW'(TIMEOUT - 1);

    arb_state_t               state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CH_BITS-1:0]       ptr_q;
    logic [CH_BITS-1:0]       chan_q;
    logic [NCH-1:0]           hold_q;
    logic [NCH-1:0][DW-1:0]   hold_data_q;
    logic [DW-1:0]            mix_data_q;
    logic                     mix_valid_q;
    logic                     timeout_q;

    logic                     w_gnt_any;
    logic [CH_BITS-1:0]       w_gnt_idx;
    logic                     w_beat;
    logic                     w_issue;
    logic                     w_done;
    logic                     w_abort;

    rr_pick #(
        .N (NCH)
    ) u_rr_pick (
        .req_i     (hold_q),
        .ptr_i     (ptr_q),
        .gnt_idx_o (w_gnt_idx),
        .gnt_any_o (w_gnt_any)
    );

    assign w_beat = mix_ovalid_i && mix_oready_i;

    // Next state, issue decision and watchdog; completion beats the timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_issue = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_gnt_any) begin
                    state_d = ISSUE;
                    w_issue = 1'b1;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT_I;
            end
            WAIT_I: begin
                if (w_beat && !mix_olast_i) begin
                    state_d = WAIT_Q;
                end
            end
            WAIT_Q: begin
                if (w_beat && mix_olast_i) begin
                    state_d = IDLE;
                    w_done  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            if (cnt_q == CNT_LIMIT && !w_done) begin
                state_d = IDLE;
                w_abort = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // FSM state, watchdog counter, pointer and mixer-facing registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= CH_BITS'(NCH - 1);
            chan_q      <= '0;
            mix_data_q  <= '0;
            mix_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mix_valid_q <= w_issue;
            timeout_q   <= w_abort;
            if (w_issue) begin
                mix_data_q <= hold_data_q[w_gnt_idx];
                chan_q     <= w_gnt_idx;
                ptr_q      <= w_gnt_idx;
            end
        end
    end

    // Holding registers: drain on grant, otherwise fill when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_data_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_issue && (w_gnt_idx == CH_BITS'(c))) begin
                    hold_q[c] <= 1'b0;
                end else if (ch_valid_i[c] && !hold_q[c]) begin
                    hold_q[c]      <= 1'b1;
                    hold_data_q[c] <= ch_data_i[c*DW +: DW];
                end
            end
        end
    end

    assign ch_ready_o  = ~hold_q;
    assign mix_data_o  = mix_data_q;
    assign mix_valid_o = mix_valid_q;
    assign chan_o      = chan_q;
    assign busy_o      = (state_q != IDLE);
    assign timeout_o   = timeout_q;

endmodule
`default_nettype wire
